// File: rtl/phy_chk_pkg.sv
// Shared types and helpers for the per-lane PHY output checker.
package phy_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int POP_IN_W  = 32;
  localparam int POP_OUT_W = 6;

  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

  function automatic logic [POP_OUT_W-1:0] popcount(input logic [POP_IN_W-1:0] v);
    logic [POP_OUT_W-1:0] n;
    n = '0;
    for (int i = 0; i < POP_IN_W; i++) begin
      n = n + {{(POP_OUT_W-1){1'b0}}, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/phy_chk_fifo.sv
// Single-lane expected-byte FIFO; head is the oldest entry, push+pop allowed together.
module phy_chk_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             wr_en;
  logic             rd_en;

  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);

  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));

endmodule

// File: rtl/phy_lane_checker.sv
// Per-lane scoreboard: queues expected bytes, compares them in order against PHY output.
module phy_lane_checker
  import phy_chk_pkg::*;
#(
  parameter int LANES   = 4,
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [LANES*WIDTH-1:0]     exp_data,
  input  logic [LANES-1:0]           exp_valid,
  input  logic [LANES*WIDTH-1:0]     dut_data,
  input  logic [LANES-1:0]           dut_valid,
  output logic [CNT_W-1:0]           match_count,
  output logic [CNT_W-1:0]           mismatch_count,
  output logic [LANES-1:0]           lane_error,
  output logic [LANES-1:0]           overflow,
  output logic                       timeout_err,
  output logic [$clog2(LANES)-1:0]   first_err_lane,
  output logic [WIDTH-1:0]           first_err_exp,
  output logic [WIDTH-1:0]           first_err_got,
  output logic                       busy,
  output logic                       done
);

  localparam int LW = $clog2(LANES);
  localparam int TW = $clog2(TIMEOUT + 1);

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [POP_OUT_W-1:0] n);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(n);
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  state_e           state, state_nx;
  logic             push_en, pop_en, start_run, tmo_reached, tmo_flush, fifo_clear;
  logic [LANES-1:0] empty_v, full_v, push_v, pop_v;
  logic [LANES-1:0] hit_v, miss_v, ovf_v;
  logic [WIDTH-1:0] head_v  [LANES];
  logic [WIDTH-1:0] in_b    [LANES];
  logic [WIDTH-1:0] cmp_exp [LANES];
  logic [WIDTH-1:0] cmp_got [LANES];
  logic             err_vld;
  logic [LW-1:0]    err_lane;
  logic [WIDTH-1:0] err_exp, err_got;
  logic [TW-1:0]    idle_cnt;

  assign push_en     = (state == ST_RUN);
  assign pop_en      = (state == ST_RUN) || (state == ST_DRAIN);
  assign busy        = pop_en;
  assign start_run   = ((state == ST_IDLE) || (state == ST_DONE)) && enable;
  assign tmo_reached = (idle_cnt == TW'(TIMEOUT));
  assign tmo_flush   = (state == ST_DRAIN) && tmo_reached;
  assign fifo_clear  = reset | tmo_flush;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    phy_chk_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .clear (fifo_clear),
      .push  (push_v[g]),
      .pop   (pop_v[g]),
      .din   (in_b[g]),
      .head  (head_v[g]),
      .empty (empty_v[g]),
      .full  (full_v[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (enable) state_nx = ST_RUN;
      ST_RUN:   if (!enable) state_nx = ST_DRAIN;
      ST_DRAIN: if ((&empty_v) || tmo_reached) state_nx = ST_DONE;
      ST_DONE:  if (enable) state_nx = ST_RUN;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Stage p0: per-lane push/pop decisions and compare
  always_comb begin
    err_vld  = 1'b0;
    err_lane = '0;
    err_exp  = '0;
    err_got  = '0;
    for (int i = 0; i < LANES; i++) begin
      in_b[i]    = exp_data[lane_lo(i, WIDTH) +: WIDTH];
      cmp_got[i] = dut_data[lane_lo(i, WIDTH) +: WIDTH];
      cmp_exp[i] = '0;
      push_v[i]  = 1'b0;
      pop_v[i]   = 1'b0;
      hit_v[i]   = 1'b0;
      miss_v[i]  = 1'b0;
      ovf_v[i]   = 1'b0;
      if (pop_en && dut_valid[i]) begin
        if (!empty_v[i]) begin
          cmp_exp[i] = head_v[i];
          pop_v[i]   = 1'b1;
          miss_v[i]  = (head_v[i] != cmp_got[i]);
        end else if (push_en && exp_valid[i]) begin
          cmp_exp[i] = in_b[i];
          miss_v[i]  = (in_b[i] != cmp_got[i]);
        end else begin
          miss_v[i]  = 1'b1;
        end
        hit_v[i] = ~miss_v[i];
      end
      if (push_en && exp_valid[i]) begin
        if (full_v[i] && !(pop_en && dut_valid[i])) ovf_v[i] = 1'b1;
        else if (!(empty_v[i] && pop_en && dut_valid[i])) push_v[i] = 1'b1;
      end
    end
    for (int i = LANES - 1; i >= 0; i--) begin
      if (miss_v[i]) begin
        err_vld  = 1'b1;
        err_lane = LW'(i);
        err_exp  = cmp_exp[i];
        err_got  = cmp_got[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !(|(~empty_v)) || (|dut_valid)) idle_cnt <= '0;
    else if (!tmo_reached)                       idle_cnt <= idle_cnt + 1'b1;
  end

  // Stage p1: registered compare results
  logic [LANES-1:0] hit_p1, miss_p1, ovf_p1;
  logic             vld_p1;
  logic [LW-1:0]    err_lane_p1;
  logic [WIDTH-1:0] err_exp_p1, err_got_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_p1  <= '0;
      miss_p1 <= '0;
      ovf_p1  <= '0;
      vld_p1  <= 1'b0;
    end else begin
      hit_p1  <= hit_v;
      miss_p1 <= miss_v;
      ovf_p1  <= ovf_v;
      vld_p1  <= err_vld;
    end
  end

  always_ff @(posedge clk) begin
    err_lane_p1 <= err_lane;
    err_exp_p1  <= err_exp;
    err_got_p1  <= err_got;
  end

  // Stage p2: counters, sticky flags and first-error capture
  logic first_seen;

  always_ff @(posedge clk) begin
    if (reset || start_run) begin
      match_count    <= '0;
      mismatch_count <= '0;
      lane_error     <= '0;
      overflow       <= '0;
      timeout_err    <= 1'b0;
      first_err_lane <= '0;
      first_err_exp  <= '0;
      first_err_got  <= '0;
      first_seen     <= 1'b0;
    end else begin
      match_count    <= sat_add(match_count, popcount(POP_IN_W'(hit_p1)));
      mismatch_count <= sat_add(mismatch_count, popcount(POP_IN_W'(miss_p1)));
      lane_error     <= lane_error | miss_p1 | ovf_p1;
      overflow       <= overflow | ovf_p1;
      if (tmo_reached) timeout_err <= 1'b1;
      if (vld_p1 && !first_seen) begin
        first_seen     <= 1'b1;
        first_err_lane <= err_lane_p1;
        first_err_exp  <= err_exp_p1;
        first_err_got  <= err_got_p1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) done <= 1'b0;
    else       done <= (state == ST_DRAIN) && (state_nx == ST_DONE);
  end

endmodule

// File: tb/tb_phy_lane_checker.sv
// Directed bench for phy_lane_checker with hand-computed expectations.
module tb_phy_lane_checker;

  localparam int LANES   = 4;
  localparam int WIDTH   = 8;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 64;
  localparam int CNT_W   = 16;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     enable;
  logic [LANES*WIDTH-1:0]   exp_data;
  logic [LANES-1:0]         exp_valid;
  logic [LANES*WIDTH-1:0]   dut_data;
  logic [LANES-1:0]         dut_valid;
  logic [CNT_W-1:0]         match_count;
  logic [CNT_W-1:0]         mismatch_count;
  logic [LANES-1:0]         lane_error;
  logic [LANES-1:0]         overflow;
  logic                     timeout_err;
  logic [$clog2(LANES)-1:0] first_err_lane;
  logic [WIDTH-1:0]         first_err_exp;
  logic [WIDTH-1:0]         first_err_got;
  logic                     busy;
  logic                     done;

  int vectors    = 0;
  int miscompares = 0;

  phy_lane_checker #(
    .LANES   (LANES),
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .exp_data       (exp_data),
    .exp_valid      (exp_valid),
    .dut_data       (dut_data),
    .dut_valid      (dut_valid),
    .match_count    (match_count),
    .mismatch_count (mismatch_count),
    .lane_error     (lane_error),
    .overflow       (overflow),
    .timeout_err    (timeout_err),
    .first_err_lane (first_err_lane),
    .first_err_exp  (first_err_exp),
    .first_err_got  (first_err_got),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic run_start();
    enable = 1'b1;
    tick();
  endtask

  task automatic run_end(input string tag);
    enable = 1'b0;
    tick();
    tick();
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    tick();
  endtask

  task automatic push_two();
    exp_valid = 4'hF;
    exp_data  = 32'hCCDDEEFF;
    tick();
    exp_data  = 32'h8899AABB;
    tick();
    exp_valid = 4'h0;
    exp_data  = '0;
    tick();
  endtask

  task automatic return_two(input logic [31:0] b1, input logic [31:0] b2);
    dut_valid = 4'hF;
    dut_data  = b1;
    tick();
    dut_data  = b2;
    tick();
    dut_valid = 4'h0;
    dut_data  = '0;
    tick();
  endtask

  initial begin
    int n;
    reset     = 1'b1;
    enable    = 1'b0;
    exp_data  = '0;
    exp_valid = '0;
    dut_data  = '0;
    dut_valid = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_match",    32'(match_count),    32'd0);
    chk("rst_mismatch", 32'(mismatch_count), 32'd0);
    chk("rst_lane_err", 32'(lane_error),     32'd0);
    chk("rst_ovf",      32'(overflow),       32'd0);
    chk("rst_tmo",      32'(timeout_err),    32'd0);
    chk("rst_busy",     32'(busy),           32'd0);
    chk("rst_done",     32'(done),           32'd0);

    // 1: clean four-lane traffic
    run_start();
    chk("t1_busy", 32'(busy), 32'd1);
    push_two();
    return_two(32'hCCDDEEFF, 32'h8899AABB);
    chk("t1_match",    32'(match_count),    32'd8);
    chk("t1_mismatch", 32'(mismatch_count), 32'd0);
    chk("t1_lane_err", 32'(lane_error),     32'd0);
    enable = 1'b0;
    tick();
    chk("t1_drain_busy", 32'(busy), 32'd1);
    chk("t1_drain_done", 32'(done), 32'd0);
    tick();
    chk("t1_done",      32'(done), 32'd1);
    chk("t1_busy_fall", 32'(busy), 32'd0);
    tick();
    chk("t1_done_pulse", 32'(done), 32'd0);

    // 2: lane 2 corrupted
    run_start();
    chk("t2_cleared", 32'(match_count), 32'd0);
    push_two();
    return_two(32'hCC77EEFF, 32'h8899AABB);
    chk("t2_match",    32'(match_count),    32'd7);
    chk("t2_mismatch", 32'(mismatch_count), 32'd1);
    chk("t2_lane_err", 32'(lane_error),     32'h4);
    chk("t2_fe_lane",  32'(first_err_lane), 32'd2);
    chk("t2_fe_exp",   32'(first_err_exp),  32'hDD);
    chk("t2_fe_got",   32'(first_err_got),  32'h77);
    run_end("t2");

    // 3: bypass on lane 1
    run_start();
    chk("t3_cleared_err", 32'(lane_error), 32'd0);
    exp_valid = 4'b0010;
    exp_data  = 32'h0000AA00;
    dut_valid = 4'b0010;
    dut_data  = 32'h0000AA00;
    tick();
    exp_valid = '0;
    exp_data  = '0;
    dut_valid = '0;
    dut_data  = '0;
    tick();
    chk("t3_match",    32'(match_count),    32'd1);
    chk("t3_mismatch", 32'(mismatch_count), 32'd0);
    run_end("t3_empty");

    // 4: overflow on lane 0
    run_start();
    exp_valid = 4'b0001;
    for (int i = 0; i < DEPTH + 1; i++) begin
      exp_data = 32'(8'h10 + i);
      tick();
    end
    exp_valid = '0;
    exp_data  = '0;
    tick();
    chk("t4_ovf",      32'(overflow),       32'h1);
    chk("t4_lane_err", 32'(lane_error),     32'h1);
    chk("t4_mismatch", 32'(mismatch_count), 32'd0);
    dut_valid = 4'b0001;
    for (int i = 0; i < DEPTH; i++) begin
      dut_data = 32'(8'h10 + i);
      tick();
    end
    dut_valid = '0;
    dut_data  = '0;
    tick();
    chk("t4_match",     32'(match_count),    32'd8);
    chk("t4_mismatch2", 32'(mismatch_count), 32'd0);
    run_end("t4");

    // 5: timeout while draining
    run_start();
    exp_valid = 4'b1000;
    exp_data  = 32'h42000000;
    tick();
    exp_valid = '0;
    exp_data  = '0;
    enable    = 1'b0;
    n = 0;
    while (n < 100 && !done) begin
      tick();
      n++;
    end
    chk("t5_cycles", 32'(n),           32'd65);
    chk("t5_tmo",    32'(timeout_err), 32'd1);
    chk("t5_busy",   32'(busy),        32'd0);
    tick();

    // 5b: flushed FIFOs give unexpected data; lowest lane wins
    run_start();
    chk("t5b_tmo_clr", 32'(timeout_err), 32'd0);
    dut_valid = 4'b1010;
    dut_data  = 32'h42001100;
    tick();
    dut_valid = '0;
    dut_data  = '0;
    tick();
    chk("t5b_mismatch", 32'(mismatch_count), 32'd2);
    chk("t5b_lane_err", 32'(lane_error),     32'hA);
    chk("t5b_fe_lane",  32'(first_err_lane), 32'd1);
    chk("t5b_fe_exp",   32'(first_err_exp),  32'h00);
    chk("t5b_fe_got",   32'(first_err_got),  32'h11);
    run_end("t5b");

    // 6: unexpected data then mid-run reset
    run_start();
    dut_valid = 4'b0001;
    dut_data  = 32'h0000005A;
    tick();
    dut_valid = '0;
    dut_data  = '0;
    tick();
    chk("t6_mismatch", 32'(mismatch_count), 32'd1);
    chk("t6_fe_lane",  32'(first_err_lane), 32'd0);
    chk("t6_fe_exp",   32'(first_err_exp),  32'h00);
    chk("t6_fe_got",   32'(first_err_got),  32'h5A);
    reset = 1'b1;
    tick();
    reset  = 1'b0;
    enable = 1'b0;
    chk("t6_rst_mismatch", 32'(mismatch_count), 32'd0);
    chk("t6_rst_lane_err", 32'(lane_error),     32'd0);
    chk("t6_rst_fe_got",   32'(first_err_got),  32'd0);
    chk("t6_rst_busy",     32'(busy),           32'd0);
    tick();
    chk("t6_idle_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/phy_lane_checker.md
Name: phy_lane_checker

Overview:
- Parametrised, self-checking per-lane scoreboard for the multi-lane PHY datapath.
- Captures the expected byte stream for each lane, as sent into the PHY with its valid qualifier, in per-lane FIFOs.
- Compares each FIFO entry, in order, against the byte that later arrives on the matching lane at the PHY output. This absorbs arbitrary PHY latency.
- Reports match/mismatch counts, sticky per-lane errors, first-error capture, overflow and timeout. Sits between the stimulus generator and the PHY output in the PHY bench and in on-chip BIST.

Parameters:
- LANES, 4, number of lanes.
- WIDTH, 8, data bits per lane.
- DEPTH, 8, per-lane expected-FIFO entries; power of two, at least 2.
- TIMEOUT, 64, cycles allowed with pending expected data and no output valid on any lane.
- CNT_W, 16, width of the match and mismatch counters.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  run request; high = accept expected data.
- exp_data  in  LANES*WIDTH  expected bytes; lane i is bits [i*WIDTH +: WIDTH].
- exp_valid  in  LANES  per-lane push qualifier.
- dut_data  in  LANES*WIDTH  PHY output bytes, same packing.
- dut_valid  in  LANES  per-lane PHY output valid.
- match_count  out  CNT_W  number of matched lane-bytes.
- mismatch_count  out  CNT_W  number of mismatched or unexpected lane-bytes.
- lane_error  out  LANES  sticky per-lane error flag.
- overflow  out  LANES  sticky per-lane push-while-full flag.
- timeout_err  out  1  sticky timeout flag.
- first_err_lane  out  $clog2(LANES)  lane of the first error in the run.
- first_err_exp  out  WIDTH  expected byte at the first error.
- first_err_got  out  WIDTH  received byte at the first error.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  one-cycle pulse on entry to DONE.

Behaviour:
- Reset: all outputs 0; FIFOs empty; state IDLE.
- States: IDLE, RUN, DRAIN, DONE; encoding lives in the package.
  - IDLE -> RUN when enable=1.
  - RUN -> DRAIN when enable=0.
  - DRAIN -> DONE when all FIFOs are empty, or on timeout.
  - DONE -> RUN when enable=1.
- Entering RUN clears the counters, the sticky flags and the first-error fields. FIFOs are already empty at that point.
- Push: only in RUN. exp_valid[i] writes lane i's byte. In IDLE, DRAIN and DONE, exp_valid is ignored.
- Pop/compare: active in RUN and DRAIN. On dut_valid[i], the FIFO head for lane i is compared with lane i of dut_data.
  - Equal: counts as a match.
  - Not equal: counts as a mismatch and sets lane_error[i].
  - Results are registered: counters and flags update one cycle after the valid.
- Unexpected data: dut_valid[i] with FIFO i empty and no same-cycle push counts as a mismatch and sets lane_error[i]. first_err_exp records 0.
- Bypass: FIFO i empty with push and pop in the same cycle compares dut_data against exp_data directly. Nothing is stored.
- Full FIFO:
  - Push without pop sets overflow[i] and lane_error[i]; the byte is dropped.
  - Push with pop is legal; occupancy stays at DEPTH.
- Multiple lanes in one cycle: each counter adds the number of lanes with that result. Counters saturate at 2^CNT_W-1.
- First error: latched once per run. With simultaneous errors, the lowest lane index wins.
- Timeout:
  - An idle counter runs while any FIFO is non-empty and no dut_valid bit is set.
  - It clears on any dut_valid, and when all FIFOs are empty.
  - When it reaches TIMEOUT, timeout_err is set. In DRAIN this forces DONE and flushes the FIFOs.
- Reset mid-run returns to IDLE, flushes the FIFOs and clears all outputs in the next cycle.
- dut_valid in IDLE or DONE is ignored.

Decomposition:
- Package phy_chk_pkg: state typedef/localparams; helper function for the lane slice; popcount function.
- Sub-module phy_chk_fifo: single-lane synchronous FIFO (WIDTH, DEPTH).
  - Outputs: head, empty, full.
  - Push and pop in the same cycle are allowed.
  - Instantiated LANES times with a generate loop.
- Top level: FSM, bypass, compare, counters, timeout.

Test Plan:
1. Lanes 0..3 push FF, EE, DD, CC, then BB, AA, 99, 88; same bytes return 3 cycles later on all lanes -> match_count=8, mismatch_count=0, lane_error=0. Drop enable -> done pulses once, busy falls.
2. Same pushes; lane 2 returns 77 instead of DD -> mismatch_count=1, lane_error=4'b0100, first_err_lane=2, first_err_exp=DD, first_err_got=77, match_count=7.
3. Push and return in the same cycle with empty FIFOs (bypass), lane 1 = AA/AA -> match_count=1, FIFO 1 stays empty.
4. Push DEPTH+1 bytes on lane 0 with no dut_valid -> overflow=4'b0001, lane_error[0]=1. The 9th byte is dropped; the later 8 returns all match.
5. Push one byte on lane 3, then hold dut_valid=0 and drop enable -> timeout_err=1 after 64 idle cycles, state reaches DONE, FIFOs empty.
6. dut_valid on lane 0 with empty FIFO during RUN -> mismatch_count=1, first_err_exp=0. Assert reset mid-run -> all outputs 0 next cycle, state IDLE.
